threshold_pulse_gen: RTL and testbench

- Sits directly downstream of the per-channel DAC/filter stage and consumes its threshold comparator output (thrsh_out) and window-discriminator output (fsm_inwin_out).
- Converts the level-type threshold crossing into a clean, fixed-length TTL pulse with a refractory lockout, one evaluation per amplifier sample period.
- Keeps a saturating event counter for host readout.
- One instance per DAC channel; the TTL output feeds the digital-out mux.

---
 rtl/threshold_pulse_gen.sv | 171 +++++++++++++++++
 tb/tb_threshold_pulse_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_pulse_gen.sv
// threshold_pulse_gen
//   Turns the level-type threshold comparator output of a DAC channel into a
//   fixed-length TTL pulse followed by a refractory lockout. State advances
//   once per amplifier sample period (sample_strobe). Accepted triggers are
//   counted in a saturating event counter for host readout.
//
// Ports
//   dataclk        : system data clock, all logic on the rising edge
//   reset_n        : asynchronous active-low reset
//   sample_strobe  : one-dataclk pulse per sample period
//   en             : block enable; low forces IDLE immediately (next dataclk)
//   thrsh_in       : threshold comparator level
//   inwin_in       : window discriminator level
//   gate_en        : 1 = triggers only accepted while inwin_in is high
//   pulse_len      : TTL high time in sample periods (0 = no pulse)
//   refractory_len : lockout after the pulse in sample periods (0 = none)
//   count_clear    : synchronous clear of event_count (wins over increment)
//   ttl_out        : registered TTL pulse
//   busy           : high while in PULSE or REFRACT
//   event_strobe   : one-dataclk pulse per accepted trigger
//   event_count    : saturating count of accepted triggers
module threshold_pulse_gen #(
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   dataclk,
  input  logic                   reset_n,
  input  logic                   sample_strobe,
  input  logic                   en,
  input  logic                   thrsh_in,
  input  logic                   inwin_in,
  input  logic                   gate_en,
  input  logic [LEN_WIDTH-1:0]   pulse_len,
  input  logic [LEN_WIDTH-1:0]   refractory_len,
  input  logic                   count_clear,
  output logic                   ttl_out,
  output logic                   busy,
  output logic                   event_strobe,
  output logic [COUNT_WIDTH-1:0] event_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]   ref_q, ref_d;
  logic                   ttl_q, ttl_d;
  logic                   busy_q, busy_d;
  logic                   evs_q, evs_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   thrsh_prev_q, thrsh_prev_d;
  logic                   trigger;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (v == '1) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 1'b1;
    end
  endfunction

  always_comb begin
    // Rising edge in the sample domain, optionally qualified by the window.
    trigger      = sample_strobe & en & thrsh_in & ~thrsh_prev_q &
                   (~gate_en | inwin_in);
    state_d      = state_q;
    cnt_d        = cnt_q;
    ref_d        = ref_q;
    ttl_d        = ttl_q;
    evs_d        = 1'b0;
    count_d      = count_q;
    thrsh_prev_d = thrsh_prev_q;

    if (!en) begin
      // Disable aborts any event in progress, independent of the strobe.
      state_d      = ST_IDLE;
      ttl_d        = 1'b0;
      cnt_d        = '0;
      thrsh_prev_d = 1'b0;
    end else if (sample_strobe) begin
      thrsh_prev_d = thrsh_in;
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            evs_d = 1'b1;
            // Refractory length is latched now so later input changes do
            // not stretch or shorten the current event.
            ref_d = refractory_len;
            if (pulse_len != '0) begin
              state_d = ST_PULSE;
              ttl_d   = 1'b1;
              cnt_d   = pulse_len;
            end else if (refractory_len != '0) begin
              state_d = ST_REFRACT;
              cnt_d   = refractory_len;
            end
          end
        end
        ST_PULSE: begin
          if (cnt_q == LEN_WIDTH'(1)) begin
            ttl_d = 1'b0;
            if (ref_q != '0) begin
              state_d = ST_REFRACT;
              cnt_d   = ref_q;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_REFRACT: begin
          // A trigger on the exiting strobe is deliberately not taken.
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ttl_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end

    if (count_clear) begin
      count_d = '0;
    end else if (evs_d) begin
      count_d = sat_inc(count_q);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ref_q        <= '0;
      ttl_q        <= 1'b0;
      busy_q       <= 1'b0;
      evs_q        <= 1'b0;
      count_q      <= '0;
      thrsh_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ref_q        <= ref_d;
      ttl_q        <= ttl_d;
      busy_q       <= busy_d;
      evs_q        <= evs_d;
      count_q      <= count_d;
      thrsh_prev_q <= thrsh_prev_d;
    end
  end

  assign ttl_out      = ttl_q;
  assign busy         = busy_q;
  assign event_strobe = evs_q;
  assign event_count  = count_q;

endmodule

// File: tb/tb_threshold_pulse_gen.sv
module tb_threshold_pulse_gen;
  localparam int LW   = 16;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic          dataclk = 1'b0;
  logic          reset_n;
  logic          sample_strobe, en, thrsh_in, inwin_in, gate_en, count_clear;
  logic [LW-1:0] pulse_len, refractory_len;
  logic          ttl_out, busy, event_strobe;
  logic [CW-1:0] event_count;

  always #5 dataclk = ~dataclk;

  threshold_pulse_gen #(.LEN_WIDTH(LW), .COUNT_WIDTH(CW)) dut (
    .dataclk(dataclk), .reset_n(reset_n), .sample_strobe(sample_strobe),
    .en(en), .thrsh_in(thrsh_in), .inwin_in(inwin_in), .gate_en(gate_en),
    .pulse_len(pulse_len), .refractory_len(refractory_len),
    .count_clear(count_clear), .ttl_out(ttl_out), .busy(busy),
    .event_strobe(event_strobe), .event_count(event_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: an accepted trigger opens a lockout window of
  // pulse_len + refractory_len strobes, of which the first pulse_len have
  // the TTL high. Triggers are only accepted while no window is open.
  bit m_prev;
  int m_lock;
  int m_ttl_left;
  int m_count;
  bit m_evs;

  function automatic void model_reset();
    m_prev = 0; m_lock = 0; m_ttl_left = 0; m_count = 0; m_evs = 0;
  endfunction

  function automatic void model_step();
    bit acc;
    bit edge_ok;
    acc = 0;
    if (!en) begin
      m_lock = 0; m_ttl_left = 0; m_prev = 0;
    end else if (sample_strobe) begin
      edge_ok = thrsh_in && !m_prev && (!gate_en || inwin_in);
      if (m_lock > 0) begin
        m_lock--;
        if (m_ttl_left > 0) m_ttl_left--;
      end else if (edge_ok) begin
        acc        = 1;
        m_ttl_left = int'(pulse_len);
        m_lock     = int'(pulse_len) + int'(refractory_len);
      end
      m_prev = thrsh_in;
    end
    m_evs = acc;
    if (count_clear) m_count = 0;
    else if (acc && m_count < CMAX) m_count++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge dataclk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ttl"},   32'(ttl_out),      32'(m_ttl_left > 0));
    chk({tag, "_busy"},  32'(busy),         32'(m_lock > 0));
    chk({tag, "_evs"},   32'(event_strobe), 32'(m_evs));
    chk({tag, "_count"}, 32'(event_count),  32'(m_count));
  endtask

  task automatic set_in(input logic st, input logic e, input logic th,
                        input logic win, input logic gt, input logic clr,
                        input logic [LW-1:0] pl, input logic [LW-1:0] rl);
    sample_strobe = st; en = e; thrsh_in = th; inwin_in = win; gate_en = gt;
    count_clear = clr; pulse_len = pl; refractory_len = rl;
  endtask

  typedef struct {
    logic st, en, th, win, gt, clr;
    logic [LW-1:0] pl, rl;
    logic e_ttl, e_busy, e_evs;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic e, input logic th,
                              input logic win, input logic gt, input logic clr,
                              input logic t, input logic b, input logic v,
                              input logic [CW-1:0] c);
    vec_t r;
    r.st = st; r.en = e; r.th = th; r.win = win; r.gt = gt; r.clr = clr;
    r.pl = 16'd3; r.rl = 16'd0;
    r.e_ttl = t; r.e_busy = b; r.e_evs = v; r.e_cnt = c;
    return r;
  endfunction

  initial begin
    set_in(0, 0, 0, 0, 0, 0, '0, '0);
    reset_n = 1'b0;
    model_reset();

    // Table: pulse_len=3, refractory_len=0.
    //              st en th wn gt cl  ttl busy evs cnt
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0,  0,  0,  0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,  1,  1,  1,  1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,  1,  1,  0,  1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,  1,  1,  0,  1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,  1,  1,  0,  1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,  0,  0,  0,  1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,  0,  0,  0,  1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  0,  0,  0,  1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,  1,  1,  1,  2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0,  0,  0,  0,  2));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,  1,  1,  1,  3));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1,  1,  1,  0,  0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,  1,  1,  0,  0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0,  0,  0,  0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0,  0,  0,  0,  0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0,  0,  0,  0,  0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0,  0,  0,  0,  0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0,  1,  1,  1,  1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  1,  1,  0,  1));

    // Reset state
    #12;
    chk("rst_ttl", 32'(ttl_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_evs", 32'(event_strobe), 0);
    chk("rst_count", 32'(event_count), 0);
    @(negedge dataclk);
    reset_n = 1'b1;
    tick();

    // Table-driven vectors
    foreach (tbl[i]) begin
      set_in(tbl[i].st, tbl[i].en, tbl[i].th, tbl[i].win, tbl[i].gt,
             tbl[i].clr, tbl[i].pl, tbl[i].rl);
      tick();
      chk($sformatf("tbl%0d_ttl", i),   32'(ttl_out),      32'(tbl[i].e_ttl));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),         32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_evs", i),   32'(event_strobe), 32'(tbl[i].e_evs));
      chk($sformatf("tbl%0d_count", i), 32'(event_count),  32'(tbl[i].e_cnt));
    end

    // Refractory lockout: pulse 2, refractory 4, thrsh toggling each strobe
    set_in(0, 0, 0, 0, 0, 0, 16'd2, 16'd4);
    tick();
    check_model("refr_abort");
    set_in(1, 1, 0, 0, 0, 1, 16'd2, 16'd4);
    tick();
    check_model("refr_clr");
    for (int k = 0; k < 13; k++) begin
      set_in(1, 1, (k % 2) == 0, 0, 0, 0, 16'd2, 16'd4);
      tick();
      check_model($sformatf("refr%0d", k));
    end
    chk("refr_total", 32'(event_count), 2);

    // Saturation with zero lengths
    set_in(1, 1, 0, 0, 0, 1, 16'd0, 16'd0);
    tick();
    for (int k = 0; k < 2 * (CMAX + 2); k++) begin
      set_in(1, 1, (k % 2) == 1, 0, 0, 0, 16'd0, 16'd0);
      tick();
      check_model("zero");
    end
    chk("sat_count", 32'(event_count), CMAX);
    set_in(1, 1, 0, 0, 0, 0, 16'd0, 16'd0);
    tick();
    set_in(1, 1, 1, 0, 0, 1, 16'd0, 16'd0);
    tick();
    chk("clr_vs_trig_count", 32'(event_count), 0);
    chk("clr_vs_trig_evs", 32'(event_strobe), 1);

    // Abort via en during a long pulse
    set_in(1, 1, 0, 0, 0, 0, 16'd100, 16'd5);
    tick();
    set_in(1, 1, 1, 0, 0, 0, 16'd100, 16'd5);
    tick();
    chk("abort_start_ttl", 32'(ttl_out), 1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_model("long");
    end
    set_in(0, 0, 1, 0, 0, 0, 16'd100, 16'd5);
    tick();
    chk("abort_ttl", 32'(ttl_out), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_count", 32'(event_count), 1);

    // Asynchronous reset mid-pulse, then trigger on the first strobe after
    set_in(1, 1, 0, 0, 0, 0, 16'd100, 16'd5);
    tick();
    set_in(1, 1, 1, 0, 0, 0, 16'd100, 16'd5);
    tick();
    tick();
    chk("pre_rst_ttl", 32'(ttl_out), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ttl", 32'(ttl_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_evs", 32'(event_strobe), 0);
    chk("arst_count", 32'(event_count), 0);
    model_reset();
    @(negedge dataclk);
    reset_n = 1'b1;
    tick();
    chk("post_rst_evs", 32'(event_strobe), 1);
    chk("post_rst_ttl", 32'(ttl_out), 1);
    chk("post_rst_count", 32'(event_count), 1);

    // Randomized stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      set_in(1'($urandom_range(0, 1)), $urandom_range(0, 19) != 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0,
             16'($urandom_range(0, 4)), 16'($urandom_range(0, 4)));
      tick();
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
